// File: rtl/barrel_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional feature macro: ONEHOT_AMT_EN (consumed by the top level).
package barrel_pkg;

  // Shift modes as carried on in_mode and through every stage.
  typedef enum logic [1:0] {
    SH_LSR = 2'b00,
    SH_LSL = 2'b01,
    SH_ROR = 2'b10,
    SH_ASR = 2'b11
  } shift_mode_t;

  // Number of log2 stages (and binary amount width) for a given data width.
  function automatic int calc_aw(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage of the barrel shifter: a valid/ready register slice
// whose input side conditionally shifts by 2^STAGE in the selected mode.
//
// Handshake: a transfer happens on a cycle where valid && ready are both 1;
// the producer holds valid and payload stable until that transfer, and
// ready never depends on the same side's valid.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 0,
  parameter int AW    = calc_aw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [AW-1:0]    in_amt,
  input  logic             in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [AW-1:0]    out_amt,
  output logic             out_err
);

  localparam int DIST = 1 << STAGE;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [AW-1:0]    amt_q, amt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] shifted;
  logic             load;

  // Mode-dependent shift by DIST when this stage's amount bit is set.
  // Arithmetic right uses the current MSB as fill: earlier arithmetic
  // stages preserve the MSB, so it is still the original sign bit.
  always_comb begin
    shifted = in_data;
    if (in_amt[STAGE]) begin
      case (shift_mode_t'(in_mode))
        SH_LSR:  shifted = in_data >> DIST;
        SH_LSL:  shifted = in_data << DIST;
        SH_ROR:  shifted = (in_data >> DIST) | (in_data << (WIDTH - DIST));
        SH_ASR:  shifted = WIDTH'($signed(in_data) >>> DIST);
        default: shifted = in_data;
      endcase
    end
  end

  // Slice control: accept when empty or when the held word leaves this cycle.
  always_comb begin
    load     = !valid_q || out_ready;
    in_ready = load;
    valid_d  = valid_q;
    data_d   = data_q;
    mode_d   = mode_q;
    amt_d    = amt_q;
    err_d    = err_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = shifted;
        mode_d = in_mode;
        amt_d  = in_amt;
        err_d  = in_err;
      end
    end
  end

  // Stage registers; reset empties the slice and clears the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= '0;
      amt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign out_amt   = amt_q;
  assign out_err   = err_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: AW valid/ready stages, stage s shifts by 2^s.
// Modes: 00 logical right, 01 logical left, 10 rotate right, 11 arithmetic right.
// Optional macro ONEHOT_AMT_EN: in_amt becomes a WIDTH-bit one-hot amount;
// zero or multi-hot amounts flag out_err and force out_data to 0.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = calc_aw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef ONEHOT_AMT_EN
  input  logic [WIDTH-1:0] in_amt,
`else
  input  logic [AW-1:0]    in_amt,
`endif
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic             v_w [0:AW];
  logic             r_w [0:AW];
  logic [WIDTH-1:0] d_w [0:AW];
  logic [1:0]       m_w [0:AW];
  logic [AW-1:0]    a_w [0:AW];
  logic             e_w [0:AW];

  logic [AW-1:0]    amt_bin;
  logic             amt_err;

`ifdef ONEHOT_AMT_EN
  logic [AW:0]      ones;

  // Encode the one-hot amount to binary; anything but exactly one bit is illegal.
  always_comb begin
    amt_bin = '0;
    ones    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_amt[i]) begin
        amt_bin = amt_bin | AW'(i);
        ones    = ones + (AW+1)'(1);
      end
    end
    amt_err = (ones != (AW+1)'(1));
  end
`else
  // Binary amount passes straight into stage 0; no illegal encodings exist.
  always_comb begin
    amt_bin = in_amt;
    amt_err = 1'b0;
  end
`endif

  assign v_w[0]   = in_valid;
  assign in_ready = r_w[0];
  assign d_w[0]   = in_data;
  assign m_w[0]   = in_mode;
  assign a_w[0]   = amt_bin;
  assign e_w[0]   = amt_err;
  assign r_w[AW]  = out_ready;

  for (genvar s = 0; s < AW; s++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .STAGE (s),
      .AW    (AW)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_w[s]),
      .in_ready  (r_w[s]),
      .in_data   (d_w[s]),
      .in_mode   (m_w[s]),
      .in_amt    (a_w[s]),
      .in_err    (e_w[s]),
      .out_valid (v_w[s+1]),
      .out_ready (r_w[s+1]),
      .out_data  (d_w[s+1]),
      .out_mode  (m_w[s+1]),
      .out_amt   (a_w[s+1]),
      .out_err   (e_w[s+1])
    );
  end

  assign out_valid = v_w[AW];
  assign out_data  = e_w[AW] ? '0 : d_w[AW];
`ifdef ONEHOT_AMT_EN
  assign out_err   = e_w[AW];
`else
  assign out_err   = 1'b0;
`endif

endmodule
